mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
Data-memory access sequencer placed directly downstream of the mem stage's MAR/MDR muxes and upstream of the data-cache port.
- Accepts one load/store request per instruction from the EX/MEM stage and drives the cache read/write handshake.
- Performs the two-access sequence for LDI/STI: pointer fetch, then data access.
- Holds the pipeline stalled until the access completes, and returns aligned, extended read data for writeback.

Parameters:
WIDTH, 16, address/data width
TIMEOUT, 255, max wait cycles for dmem_resp per access before abort (8-bit counter)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  EX/MEM holds a valid instruction
req_read  in  1  load (LDR/LDB/LDI)
req_write  in  1  store (STR/STB/STI)
req_indirect  in  1  LDI/STI two-access sequence
req_byte  in  1  byte access (LDB/STB)
req_addr  in  WIDTH  effective address (marmux_out)
req_wdata  in  WIDTH  store data (mdrmux_out)
stall  out  1  freeze pipeline
rdata  out  WIDTH  load result to MEM/WB
rdata_valid  out  1  one-cycle pulse, rdata valid
dmem_read  out  1  cache read strobe
dmem_write  out  1  cache write strobe
dmem_addr  out  WIDTH  cache address
dmem_wdata  out  WIDTH  cache write data
dmem_byte_enable  out  2  byte lanes [1]=high, [0]=low
dmem_resp  in  1  cache done
dmem_rdata  in  WIDTH  cache read data
timeout_err  out  1  sticky abort flag

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values: state=IDLE; all outputs 0; captured address, data, op and pointer registers 0.
- Reset asserted mid-access: the access is abandoned immediately. dmem_read and dmem_write are decoded from state, so they drop asynchronously.
- FSM states: IDLE, PTR, ACCESS, DONE.
- IDLE: when req_valid & (req_read | req_write):
  - capture addr, wdata, byte, op and indirect;
  - next state is PTR if indirect, else ACCESS.
- If req_read and req_write are both set, the request is treated as a write.
- stall = req_valid & (req_read | req_write) & (state != DONE). It is combinational, so it is asserted in the request's IDLE cycle.
- PTR:
  - dmem_read=1, dmem_byte_enable=2'b11, address = captured addr;
  - on dmem_resp: ptr <= dmem_rdata, go to ACCESS.
- ACCESS:
  - effective address eaddr = ptr if indirect, else captured addr;
  - dmem_read or dmem_write per op;
  - on dmem_resp: capture read data, go to DONE.
- DONE:
  - stall=0; rdata_valid=1 for exactly this cycle (loads and stores alike; rdata=0 for stores);
  - next state is IDLE. The next request is accepted the following cycle.
- Address: dmem_addr = {eaddr[15:1], 1'b0} always (word-addressed port).
- Byte enables:
  - word access: 2'b11;
  - byte access: eaddr[0] ? 2'b10 : 2'b01.
- Store data:
  - word: captured wdata;
  - byte: {wdata[7:0], wdata[7:0]}.
- Load data:
  - word: dmem_rdata;
  - byte: the selected byte (high if eaddr[0]), sign-extended to 16 bits.
- dmem_resp in IDLE or DONE: ignored.
- dmem_read/dmem_write stay high continuously through PTR/ACCESS until dmem_resp is seen.
- Latency: non-indirect access with dmem_resp on the first ACCESS cycle:
  - request seen cycle 0, ACCESS cycle 1, DONE cycle 2;
  - stall high for cycles 0–1.
- Indirect access adds at least 1 cycle (the PTR state).
- Timeout:
  - the wait counter clears on entry to PTR/ACCESS and increments each cycle without dmem_resp;
  - when it equals TIMEOUT: set timeout_err, drop strobes, go to DONE with rdata=0.
  - timeout_err is cleared only by reset.

Test Plan:
- Word load, addr 0x3001, dmem_resp on the 1st ACCESS cycle, dmem_rdata 0xBEEF -> dmem_addr 0x3000, byte_enable 11; stall 2 cycles; rdata 0xBEEF with rdata_valid in cycle 2.
- Byte load, addr 0x4001, dmem_rdata 0x80FF -> byte_enable 10, rdata 0xFF80. Same data at addr 0x4000 -> rdata 0xFFFF.
- STB, addr 0x2000, wdata 0x1234 -> dmem_write, dmem_wdata 0x3434, byte_enable 01, rdata_valid pulse, rdata 0.
- LDI, addr 0x1000; PTR read returns 0x5002 after 3 wait cycles; data 0x0042 -> second read at 0x5002, rdata 0x0042; stall held throughout, deasserts in DONE.
- No dmem_resp with TIMEOUT=4 -> strobes drop after 4 wait cycles, timeout_err=1 sticky, rdata 0, pipeline released.
- Reset asserted during ACCESS -> dmem_read low immediately, state IDLE, stall reflects only the request inputs; a new request then completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer between the MEM stage muxes and the dcache port.
// Handles word/byte loads and stores plus the two-access LDI/STI pointer sequence.
module mem_access_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_read,
  input  logic             req_write,
  input  logic             req_indirect,
  input  logic             req_byte,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             stall,
  output logic [WIDTH-1:0] rdata,
  output logic             rdata_valid,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [1:0]       dmem_byte_enable,
  input  logic             dmem_resp,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic             timeout_err
);

  typedef enum logic [1:0] {IDLE, PTR, ACCESS, DONE} state_e;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             byte_q, byte_d;
  logic             wr_q, wr_d;
  logic             ind_q, ind_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             req_go;
  logic             to_hit;
  logic [WIDTH-1:0] eaddr;
  logic [7:0]       ld_byte;
  logic [WIDTH-1:0] ld_data;

  assign req_go  = req_valid & (req_read | req_write);
  assign to_hit  = (cnt_q == TO_LIM);
  assign eaddr   = (ind_q && state_q != PTR) ? ptr_q : addr_q;
  assign ld_byte = eaddr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
  assign ld_data = byte_q ? {{(WIDTH-8){ld_byte[7]}}, ld_byte}
                          : dmem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      ptr_q   <= '0;
      rdata_q <= '0;
      byte_q  <= 1'b0;
      wr_q    <= 1'b0;
      ind_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
      byte_q  <= byte_d;
      wr_q    <= wr_d;
      ind_q   <= ind_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    rdata_d = rdata_q;
    byte_d  = byte_q;
    wr_d    = wr_q;
    ind_d   = ind_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_go) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          byte_d  = req_byte;
          wr_d    = req_write;
          ind_d   = req_indirect;
          cnt_d   = '0;
          state_d = req_indirect ? PTR : ACCESS;
        end
      end
      PTR: begin
        // Abort takes priority: strobes are already dropped this cycle.
        if (to_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else if (dmem_resp) begin
          ptr_d   = dmem_rdata;
          cnt_d   = '0;
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ACCESS: begin
        if (to_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else if (dmem_resp) begin
          rdata_d = wr_q ? '0 : ld_data;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_byte_enable = 2'b00;
    dmem_wdata       = '0;
    unique case (state_q)
      PTR: begin
        dmem_read        = ~to_hit;
        dmem_byte_enable = to_hit ? 2'b00 : 2'b11;
      end
      ACCESS: begin
        dmem_read  = ~to_hit & ~wr_q;
        dmem_write = ~to_hit & wr_q;
        if (!to_hit)
          dmem_byte_enable = byte_q ? (eaddr[0] ? 2'b10 : 2'b01)
                                    : 2'b11;
        if (dmem_write)
          dmem_wdata = byte_q ? {wdata_q[7:0], wdata_q[7:0]}
                              : wdata_q;
      end
      default: ;
    endcase
  end

  assign dmem_addr   = {eaddr[WIDTH-1:1], 1'b0};
  assign stall       = req_go & (state_q != DONE);
  assign rdata_valid = (state_q == DONE);
  assign rdata       = rdata_q;
  assign timeout_err = err_q;

endmodule
